fofb_readout_writer: RTL and testbench

Producer side of the FOFB DSP readout interface. It collects per-BPM X/Y/S position words arriving from the cell links during each FOFB cycle into a ping-pong buffer. It serves the completed buffer through an addressed, one-cycle-latency read port. It drives the 32-bit readout CSR (active/valid handshake, fake-data select, status) consumed by the matrix-multiply/FIR block.

---
 rtl/fofb_readout_pkg.sv | 17 +
 rtl/fofb_readout_bank.sv | 75 +++++++
 rtl/fofb_readout_writer.sv | 196 +++++++++++++++++++
 tb/tb_fofb_readout_writer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fofb_readout_pkg.sv
// Shared definitions for the FOFB DSP readout interface: CSR bit positions and
// the writer state encoding.
package fofb_readout_pkg;

  localparam int unsigned CsrActive  = 31;
  localparam int unsigned CsrValid   = 30;
  localparam int unsigned CsrTimeout = 29;
  localparam int unsigned CsrLate    = 28;
  localparam int unsigned CsrOverrun = 27;
  localparam int unsigned CsrFake    = 20;

  typedef enum logic [0:0] {
    StIdle,
    StFill
  } state_e;

endpackage

// File: rtl/fofb_readout_bank.sv
// One ping-pong bank: X/Y/S storage, per-slot seen bits with single-cycle bulk
// clear, and a registered read that returns zero for unseen slots.
module fofb_readout_bank #(
  parameter int unsigned AddrWidth = 9,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [DataWidth-1:0] wx_i,
  input  logic [DataWidth-1:0] wy_i,
  input  logic [DataWidth-1:0] ws_i,
  output logic                 wseen_o,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [DataWidth-1:0] rx_o,
  output logic [DataWidth-1:0] ry_o,
  output logic [DataWidth-1:0] rs_o
);

  localparam int unsigned Depth = 2 ** AddrWidth;

  logic [Depth-1:0]     seen_q, seen_d;
  logic [DataWidth-1:0] mem_x_q [Depth];
  logic [DataWidth-1:0] mem_y_q [Depth];
  logic [DataWidth-1:0] mem_s_q [Depth];
  logic [DataWidth-1:0] rx_q, rx_d, ry_q, ry_d, rs_q, rs_d;

  always_comb begin
    seen_d = seen_q;
    if (clr_i) seen_d = '0;
    if (we_i) seen_d[waddr_i] = 1'b1;
  end

  always_comb begin
    rx_d = '0;
    ry_d = '0;
    rs_d = '0;
    if (seen_q[raddr_i]) begin
      rx_d = mem_x_q[raddr_i];
      ry_d = mem_y_q[raddr_i];
      rs_d = mem_s_q[raddr_i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q <= '0;
      rx_q   <= '0;
      ry_q   <= '0;
      rs_q   <= '0;
    end else begin
      seen_q <= seen_d;
      rx_q   <= rx_d;
      ry_q   <= ry_d;
      rs_q   <= rs_d;
    end
  end

  // Storage needs no reset: stale contents are hidden by the seen bits.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_x_q[waddr_i] <= wx_i;
      mem_y_q[waddr_i] <= wy_i;
      mem_s_q[waddr_i] <= ws_i;
    end
  end

  assign wseen_o = seen_q[waddr_i];
  assign rx_o    = rx_q;
  assign ry_o    = ry_q;
  assign rs_o    = rs_q;

endmodule

// File: rtl/fofb_readout_writer.sv
// Producer side of the FOFB DSP readout: fills one bank per FOFB cycle, serves
// the completed bank on the read port and reports progress in the readout CSR.
module fofb_readout_writer
  import fofb_readout_pkg::*;
#(
  parameter int unsigned MATRIX_COLUMN_WIDTH = 9,
  parameter int unsigned DATA_WIDTH          = 32,
  parameter int unsigned TIMEOUT_WIDTH       = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cycleStart,
  input  logic [MATRIX_COLUMN_WIDTH:0]   expectedCount,
  input  logic [TIMEOUT_WIDTH-1:0]       timeoutTicks,
  input  logic                           useFakeData,
  input  logic                           bpmValid,
  input  logic [MATRIX_COLUMN_WIDTH-1:0] bpmIndex,
  input  logic [DATA_WIDTH-1:0]          bpmX,
  input  logic [DATA_WIDTH-1:0]          bpmY,
  input  logic [DATA_WIDTH-1:0]          bpmS,
  input  logic [MATRIX_COLUMN_WIDTH-1:0] fofbDSPreadoutAddress,
  output logic [DATA_WIDTH-1:0]          fofbDSPreadoutX,
  output logic [DATA_WIDTH-1:0]          fofbDSPreadoutY,
  output logic [DATA_WIDTH-1:0]          fofbDSPreadoutS,
  output logic [31:0]                    fofbReadoutCSR
);

  localparam int unsigned CountWidth = MATRIX_COLUMN_WIDTH + 1;

  state_e                  state_q, state_d;
  logic                    wbank_q, wbank_d;
  logic                    rsel_q;
  logic                    restart_q, restart_d;
  logic [CountWidth-1:0]   count_q, count_d;
  logic [CountWidth-1:0]   rcount_q, rcount_d;
  logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
  logic                    active_q, active_d;
  logic                    valid_q, valid_d;
  logic                    timeout_q, timeout_d;
  logic                    late_q, late_d;
  logic                    overrun_q, overrun_d;
  logic                    clr, we, wseen;
  logic                    wseen0, wseen1;
  logic [TIMEOUT_WIDTH-1:0] tmo_load;
  logic [DATA_WIDTH-1:0]   rx0, ry0, rs0, rx1, ry1, rs1;

  assign tmo_load = (timeoutTicks == '0) ? TIMEOUT_WIDTH'(1) : timeoutTicks;
  assign wseen    = wbank_q ? wseen1 : wseen0;

  always_comb begin
    state_d   = state_q;
    wbank_d   = wbank_q;
    restart_d = restart_q;
    count_d   = count_q;
    rcount_d  = rcount_q;
    tmo_d     = tmo_q;
    active_d  = active_q;
    valid_d   = valid_q;
    timeout_d = timeout_q;
    late_d    = late_q;
    overrun_d = overrun_q;
    clr       = 1'b0;
    we        = 1'b0;

    unique case (state_q)
      StIdle: begin
        // restart_q carries a new cycle deferred by an overrun completion
        if (cycleStart || restart_q) begin
          clr       = 1'b1;
          count_d   = '0;
          active_d  = 1'b1;
          valid_d   = 1'b0;
          timeout_d = 1'b0;
          late_d    = 1'b0;
          overrun_d = restart_q;
          restart_d = 1'b0;
          tmo_d     = tmo_load;
          state_d   = StFill;
        end
      end
      StFill: begin
        tmo_d = tmo_q - 1'b1;
        if (bpmValid) begin
          we = 1'b1;
          if (!wseen) count_d = count_q + 1'b1;
        end
        if (cycleStart || ((expectedCount != '0) && (count_d == expectedCount)) ||
            (tmo_q <= TIMEOUT_WIDTH'(1))) begin
          wbank_d  = ~wbank_q;
          rcount_d = count_d;
          active_d = 1'b0;
          state_d  = StIdle;
          if (cycleStart) begin
            valid_d   = 1'b0;
            timeout_d = 1'b1;
            overrun_d = 1'b1;
            restart_d = 1'b1;
          end else if ((expectedCount != '0) && (count_d == expectedCount)) begin
            valid_d = 1'b1;
          end else begin
            valid_d   = 1'b0;
            timeout_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (bpmValid && (state_q != StFill)) late_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wbank_q   <= 1'b0;
      rsel_q    <= 1'b1;
      restart_q <= 1'b0;
      count_q   <= '0;
      rcount_q  <= '0;
      tmo_q     <= '0;
      active_q  <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      late_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wbank_q   <= wbank_d;
      rsel_q    <= ~wbank_q;
      restart_q <= restart_d;
      count_q   <= count_d;
      rcount_q  <= rcount_d;
      tmo_q     <= tmo_d;
      active_q  <= active_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      late_q    <= late_d;
      overrun_q <= overrun_d;
    end
  end

  fofb_readout_bank #(
    .AddrWidth (MATRIX_COLUMN_WIDTH),
    .DataWidth (DATA_WIDTH)
  ) u_bank0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr && !wbank_q),
    .we_i    (we && !wbank_q),
    .waddr_i (bpmIndex),
    .wx_i    (bpmX),
    .wy_i    (bpmY),
    .ws_i    (bpmS),
    .wseen_o (wseen0),
    .raddr_i (fofbDSPreadoutAddress),
    .rx_o    (rx0),
    .ry_o    (ry0),
    .rs_o    (rs0)
  );

  fofb_readout_bank #(
    .AddrWidth (MATRIX_COLUMN_WIDTH),
    .DataWidth (DATA_WIDTH)
  ) u_bank1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr && wbank_q),
    .we_i    (we && wbank_q),
    .waddr_i (bpmIndex),
    .wx_i    (bpmX),
    .wy_i    (bpmY),
    .ws_i    (bpmS),
    .wseen_o (wseen1),
    .raddr_i (fofbDSPreadoutAddress),
    .rx_o    (rx1),
    .ry_o    (ry1),
    .rs_o    (rs1)
  );

  // rsel_q is the read bank sampled together with the address
  assign fofbDSPreadoutX = rsel_q ? rx1 : rx0;
  assign fofbDSPreadoutY = rsel_q ? ry1 : ry0;
  assign fofbDSPreadoutS = rsel_q ? rs1 : rs0;

  always_comb begin
    fofbReadoutCSR                        = '0;
    fofbReadoutCSR[CsrActive]             = active_q;
    fofbReadoutCSR[CsrValid]              = valid_q;
    fofbReadoutCSR[CsrTimeout]            = timeout_q;
    fofbReadoutCSR[CsrLate]               = late_q;
    fofbReadoutCSR[CsrOverrun]            = overrun_q;
    fofbReadoutCSR[CsrFake]               = useFakeData;
    fofbReadoutCSR[MATRIX_COLUMN_WIDTH:0] = rcount_q;
  end

endmodule

// File: tb/tb_fofb_readout_writer.sv
// Directed bench for fofb_readout_writer: CSR checks plus a read-data scoreboard.
module tb_fofb_readout_writer;

  localparam int unsigned MW = 9;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 16;

  typedef struct {
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic [DW-1:0] s;
  } rd_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cycleStart;
  logic [MW:0]   expectedCount;
  logic [TW-1:0] timeoutTicks;
  logic          useFakeData;
  logic          bpmValid;
  logic [MW-1:0] bpmIndex;
  logic [DW-1:0] bpmX, bpmY, bpmS;
  logic [MW-1:0] rdAddr;
  logic [DW-1:0] rdX, rdY, rdS;
  logic [31:0]   csr;

  int  n_cmp = 0;
  int  n_err = 0;
  rd_t sb[$];

  localparam logic [31:0] A = 32'h8000_0000;
  localparam logic [31:0] V = 32'h4000_0000;
  localparam logic [31:0] T = 32'h2000_0000;
  localparam logic [31:0] L = 32'h1000_0000;
  localparam logic [31:0] O = 32'h0800_0000;

  always #5 clk = ~clk;

  fofb_readout_writer #(
    .MATRIX_COLUMN_WIDTH (MW),
    .DATA_WIDTH          (DW),
    .TIMEOUT_WIDTH       (TW)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .cycleStart            (cycleStart),
    .expectedCount         (expectedCount),
    .timeoutTicks          (timeoutTicks),
    .useFakeData           (useFakeData),
    .bpmValid              (bpmValid),
    .bpmIndex              (bpmIndex),
    .bpmX                  (bpmX),
    .bpmY                  (bpmY),
    .bpmS                  (bpmS),
    .fofbDSPreadoutAddress (rdAddr),
    .fofbDSPreadoutX       (rdX),
    .fofbDSPreadoutY       (rdY),
    .fofbDSPreadoutS       (rdS),
    .fofbReadoutCSR        (csr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic [31:0] exp);
    chk(tag, csr & 32'hF800_0000, exp);
  endtask

  task automatic wr(input int idx, input logic [DW-1:0] x);
    bpmValid = 1'b1;
    bpmIndex = MW'(idx);
    bpmX     = x;
    bpmY     = x + 1;
    bpmS     = x + 2;
    tick();
    bpmValid = 1'b0;
  endtask

  task automatic start();
    cycleStart = 1'b1;
    tick();
    cycleStart = 1'b0;
  endtask

  task automatic rd(input string tag, input int addr, input logic [DW-1:0] x, input bit present);
    rd_t e;
    rd_t g;
    e.x = present ? x : '0;
    e.y = present ? x + 1 : '0;
    e.s = present ? x + 2 : '0;
    sb.push_back(e);
    rdAddr = MW'(addr);
    tick();
    g = sb.pop_front();
    chk({tag, ".x"}, rdX, g.x);
    chk({tag, ".y"}, rdY, g.y);
    chk({tag, ".s"}, rdS, g.s);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; cycleStart = 1'b0; expectedCount = '0; timeoutTicks = '0;
    useFakeData = 1'b0; bpmValid = 1'b0; bpmIndex = '0; bpmX = '0; bpmY = '0;
    bpmS = '0; rdAddr = '0;
    #12;
    chk("reset_csr", csr, 32'h0);
    chk("reset_rdx", rdX, 32'h0);
    useFakeData = 1'b1;
    #1;
    chk("fake_bit", csr, 32'h0010_0000);
    useFakeData = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Count completion
    expectedCount = 3; timeoutTicks = 100;
    start();
    chk("t1_active", csr, A);
    wr(5, 32'h500);
    wr(7, 32'h700);
    chk_flags("t1_mid", A);
    wr(9, 32'h900);
    chk("t1_done", csr, V | 32'd3);
    rd("t1_rd5", 5, 32'h500, 1'b1);
    rd("t1_rd6", 6, 32'h0, 1'b0);
    rd("t1_rd9", 9, 32'h900, 1'b1);

    // Timeout completion, active window length
    expectedCount = 4; timeoutTicks = 20;
    start();
    n = 0;
    while (csr[31] && n < 200) begin
      if (n == 0) wr(1, 32'h100);
      else if (n == 1) wr(2, 32'h200);
      else tick();
      n++;
    end
    chk("t2_active_clks", 32'(n), 32'd20);
    chk("t2_csr", csr, T | 32'd2);
    rd("t2_rd1", 1, 32'h100, 1'b1);
    rd("t2_rd2", 2, 32'h200, 1'b1);
    rd("t2_rd5", 5, 32'h0, 1'b0);

    // Duplicate slot
    expectedCount = 2; timeoutTicks = 50;
    start();
    wr(3, 32'h1);
    wr(3, 32'h2);
    chk_flags("t3_not_done", A);
    wr(4, 32'h400);
    chk("t3_done", csr, V | 32'd2);
    rd("t3_rd3", 3, 32'h2, 1'b1);
    rd("t3_rd5_stale", 5, 32'h0, 1'b0);

    // Late writes
    wr(10, 32'hA00);
    chk("t4_late_idle", csr, V | L | 32'd2);
    expectedCount = 1;
    bpmValid = 1'b1; bpmIndex = 11; bpmX = 32'hB00; bpmY = 32'hB01; bpmS = 32'hB02;
    start();
    bpmValid = 1'b0;
    chk_flags("t4_late_start", A | L);
    wr(12, 32'hC00);
    chk("t4_done", csr, V | L | 32'd1);
    rd("t4_rd10", 10, 32'h0, 1'b0);
    rd("t4_rd11", 11, 32'h0, 1'b0);
    rd("t4_rd12", 12, 32'hC00, 1'b1);
    expectedCount = 4;
    start();
    chk_flags("t4_late_clr", A);

    // Overrun
    wr(20, 32'h1400);
    cycleStart = 1'b1;
    tick();
    cycleStart = 1'b0;
    chk("t5_overrun", csr, T | O | 32'd1);
    rd("t5_rd20", 20, 32'h1400, 1'b1);
    chk_flags("t5_restart", A | O);

    // Reset mid-fill
    wr(21, 32'h1500);
    chk("t6_pre_rdx", rdX, 32'h1400);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_csr", csr, 32'h0);
    chk("t6_rst_rdx", rdX, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    rd("t6_rd21", 21, 32'h0, 1'b0);

    // timeoutTicks of 0 acts as 1
    timeoutTicks = 0;
    start();
    chk_flags("t7_active", A);
    tick();
    chk("t7_done", csr, T);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
